// File: rtl/reg_bus_mux.sv
// reg_bus_mux: N-input registered bus mux with valid/ready flow control and a skid buffer.
// Define MUX_PARITY_EN to add the registered out_parity output.
module reg_bus_mux #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
`ifdef MUX_PARITY_EN
  output logic                  out_parity,
`endif
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int BW = WIDTH + SEL_W + 1;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat, out_q, out_d, skid_q, skid_d;
  logic [WIDTH-1:0] mux_data;
  logic mux_err, in_ready_q, in_ready_d, push, pop, load_out, load_skid;
  always_comb begin
    mux_data = '0;
    mux_err = 1'b1;
    for (int k = 0; k < N_IN; k++)
      if (in_select == SEL_W'(k)) begin
        mux_data = in_data[k*WIDTH +: WIDTH];
        mux_err = 1'b0;
      end
  end
  assign beat = {mux_err, in_select, mux_data};
  assign push = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;
  // Output reg takes a new beat when empty or draining; the skid catches a beat arriving under backpressure.
  always_comb begin
    load_out = (push & ((state_q == EMPTY) | ((state_q == ONE) & pop))) | ((state_q == FULL) & pop);
    load_skid = push & ~pop & (state_q == ONE);
    state_d = load_skid ? FULL :
              (((state_q == EMPTY) & push) | ((state_q == FULL) & pop)) ? ONE :
              ((state_q == ONE) & pop & ~push) ? EMPTY : state_q;
    out_d = load_out ? ((state_q == FULL) ? skid_q : beat) : out_q;
    skid_d = load_skid ? beat : skid_q;
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
      in_ready_q <= in_ready_d;
    end
`ifdef MUX_PARITY_EN
  logic out_par_q, out_par_d, skid_par_q, skid_par_d;
  always_comb begin
    out_par_d = load_out ? ((state_q == FULL) ? skid_par_q : ^mux_data) : out_par_q;
    skid_par_d = load_skid ? ^mux_data : skid_par_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
      skid_par_q <= skid_par_d;
    end
  assign out_parity = out_par_q;
`endif
  assign {out_err, out_sel, out_data} = out_q;
  assign out_valid = state_q != EMPTY;
  assign in_ready = in_ready_q;
endmodule

// File: tb/tb_reg_bus_mux.sv
// tb_reg_bus_mux: table-driven check of reg_bus_mux flow control, select/error handling and reset.
module tb_reg_bus_mux;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data;
  logic [1:0] in_select;
  logic in_valid, out_ready;
  logic in_ready, out_err, out_valid, in_ready3, out_err3, out_valid3;
  logic [7:0] out_data, out_data3;
  logic [1:0] out_sel, out_sel3;
`ifdef MUX_PARITY_EN
  logic out_parity, out_parity3;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  reg_bus_mux #(.WIDTH(8), .N_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_err(out_err),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_valid(out_valid), .out_ready(out_ready));

  reg_bus_mux #(.WIDTH(8), .N_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
    .out_err(out_err3),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity3),
`endif
    .out_valid(out_valid3), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic v; logic [1:0] sel; logic rdy;
    logic ev; logic [7:0] ed; logic [1:0] es; logic eir;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b1, 8'h22, 2'd1, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b1, 8'h22, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    in_data = 32'h44332211;
    in_select = 2'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_err", out_err, 0);
    check("reset in_ready", in_ready, 1);
`ifdef MUX_PARITY_EN
    check("reset out_parity", out_parity, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      in_select = tbl[i].sel;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), out_valid, tbl[i].ev);
      check($sformatf("v%0d in_ready", i), in_ready, tbl[i].eir);
      if (tbl[i].ev) begin
        check($sformatf("v%0d out_data", i), out_data, tbl[i].ed);
        check($sformatf("v%0d out_sel", i), out_sel, tbl[i].es);
        check($sformatf("v%0d out_err", i), out_err, 0);
        check($sformatf("v%0d n3 out_data", i), out_data3, (tbl[i].es == 2'd3) ? 8'h00 : tbl[i].ed);
        check($sformatf("v%0d n3 out_err", i), out_err3, tbl[i].es == 2'd3);
`ifdef MUX_PARITY_EN
        check($sformatf("v%0d out_parity", i), out_parity, ^tbl[i].ed);
`endif
      end
    end
    // Fill both buffers, then reset asynchronously between clock edges.
    @(negedge clk);
    in_valid = 1'b1; in_select = 2'd1; out_ready = 1'b0;
    @(negedge clk);
    in_select = 2'd2;
    @(posedge clk);
    #1;
    check("full in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_data", out_data, 0);
    check("async rst out_sel", out_sel, 0);
    check("async rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_select = 2'd2; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post rst out_valid", out_valid, 1);
    check("post rst out_data", out_data, 8'h33);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post rst drained", out_valid, 0);
`ifdef MUX_PARITY_EN
    @(negedge clk);
    in_data = 32'h44332207; in_valid = 1'b1; in_select = 2'd0;
    @(posedge clk);
    #1;
    check("parity 07", out_parity, 1);
    @(negedge clk) in_data = 32'h44332203;
    @(posedge clk);
    #1;
    check("parity 03", out_parity, 0);
    @(negedge clk) in_select = 2'd3;
    @(posedge clk);
    #1;
    check("parity err beat", out_parity3, 0);
    @(negedge clk) in_valid = 1'b0;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
